// File: rtl/csr_unit.sv
// Machine-mode CSR block: mstatus/mie/mtvec/mepc/mcause/mip, interrupt entry and MRET redirect.
// Optional 64-bit mcycle counter (0xB00/0xB80) is built only when CSR_MCYCLE_EN is defined.
module csr_unit #(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_rd,
    input  logic        csr_wr,
    input  logic        is_mret,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic [31:0] pc,
    input  logic        timer_irq,
    input  logic        ext_irq,
    output logic [31:0] csr_rdata,
    output logic        epc_taken,
    output logic [31:0] epc
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;

    localparam logic [31:0] CAUSE_EXT     = 32'h8000_000B;
    localparam logic [31:0] CAUSE_TMR     = 32'h8000_0007;
    localparam logic [31:0] ALIGN_MASK    = 32'hFFFF_FFFC;

    logic        mst_mie_q,  mst_mie_d;
    logic        mst_mpie_q, mst_mpie_d;
    logic        mie_mtie_q, mie_mtie_d;
    logic        mie_meie_q, mie_meie_d;
    logic        mip_mtip_q;
    logic        mip_meip_q;
    logic [31:0] mtvec_q,    mtvec_d;
    logic [31:0] mepc_q,     mepc_d;
    logic [31:0] mcause_q,   mcause_d;

    logic        irq_ext;
    logic        irq_tmr;
    logic        irq_req;
    logic        trap;
    logic        wr_en;
    logic [31:0] rdata_mux;

    // Interrupt decision is purely from registered state, so the redirect
    // never depends combinationally on the raw irq pins.
    always_comb begin
        irq_ext = mie_meie_q & mip_meip_q;
        irq_tmr = mie_mtie_q & mip_mtip_q;
        irq_req = mst_mie_q & (irq_ext | irq_tmr);
        trap    = irq_req & ~is_mret;
        wr_en   = csr_wr & ~trap;
    end

    assign epc_taken = rst_n & (trap | is_mret);
    assign epc       = is_mret ? mepc_q : mtvec_q;

`ifdef CSR_MCYCLE_EN
    logic [63:0] mcycle_q, mcycle_d;

    // A write to either half replaces the increment for that cycle.
    always_comb begin
        if (wr_en && (csr_addr == ADDR_MCYCLE)) begin
            mcycle_d = {mcycle_q[63:32], csr_wdata};
        end else if (wr_en && (csr_addr == ADDR_MCYCLEH)) begin
            mcycle_d = {csr_wdata, mcycle_q[31:0]};
        end else begin
            mcycle_d = mcycle_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcycle_q <= 64'd0;
        end else begin
            mcycle_q <= mcycle_d;
        end
    end
`endif

    always_comb begin
        rdata_mux = 32'd0;
        case (csr_addr)
            ADDR_MSTATUS: rdata_mux = {24'd0, mst_mpie_q, 3'd0, mst_mie_q, 3'd0};
            ADDR_MIE:     rdata_mux = {20'd0, mie_meie_q, 3'd0, mie_mtie_q, 7'd0};
            ADDR_MTVEC:   rdata_mux = mtvec_q;
            ADDR_MEPC:    rdata_mux = mepc_q;
            ADDR_MCAUSE:  rdata_mux = mcause_q;
            ADDR_MIP:     rdata_mux = {20'd0, mip_meip_q, 3'd0, mip_mtip_q, 7'd0};
`ifdef CSR_MCYCLE_EN
            ADDR_MCYCLE:  rdata_mux = mcycle_q[31:0];
            ADDR_MCYCLEH: rdata_mux = mcycle_q[63:32];
`endif
            default:      rdata_mux = 32'd0;
        endcase
        csr_rdata = (rst_n && csr_rd) ? rdata_mux : 32'd0;
    end

    // Trap and MRET updates are applied after the CSR write so they override
    // any write to the same mstatus bits in that cycle.
    always_comb begin
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        mie_mtie_d = mie_mtie_q;
        mie_meie_d = mie_meie_q;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;

        if (wr_en) begin
            case (csr_addr)
                ADDR_MSTATUS: begin
                    mst_mie_d  = csr_wdata[3];
                    mst_mpie_d = csr_wdata[7];
                end
                ADDR_MIE: begin
                    mie_mtie_d = csr_wdata[7];
                    mie_meie_d = csr_wdata[11];
                end
                ADDR_MTVEC:  mtvec_d  = csr_wdata & ALIGN_MASK;
                ADDR_MEPC:   mepc_d   = csr_wdata & ALIGN_MASK;
                ADDR_MCAUSE: mcause_d = csr_wdata;
                default: ;
            endcase
        end

        if (trap) begin
            mepc_d     = pc & ALIGN_MASK;
            mcause_d   = irq_ext ? CAUSE_EXT : CAUSE_TMR;
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
        end else if (is_mret) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mie_mtie_q <= 1'b0;
            mie_meie_q <= 1'b0;
            mip_mtip_q <= 1'b0;
            mip_meip_q <= 1'b0;
            mtvec_q    <= MTVEC_RST;
            mepc_q     <= 32'd0;
            mcause_q   <= 32'd0;
        end else begin
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mie_mtie_q <= mie_mtie_d;
            mie_meie_q <= mie_meie_d;
            mip_mtip_q <= timer_irq;
            mip_meip_q <= ext_irq;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

endmodule

// File: tb/tb_csr_unit.sv
// Table-driven bench for csr_unit with an expected-value queue; covers CSR access,
// interrupt entry, MRET, priority/collision cases, reset and the optional mcycle counter.
module tb_csr_unit;

    localparam logic [31:0] MTVEC_RST_TB = 32'h0000_0200;
`ifdef CSR_MCYCLE_EN
    localparam bit MC = 1'b1;
`else
    localparam bit MC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, csr_rd, csr_wr, is_mret, timer_irq, ext_irq;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, pc, csr_rdata, epc;
    logic        epc_taken;

    always #5 clk = ~clk;

    csr_unit #(.MTVEC_RST(MTVEC_RST_TB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .csr_rd    (csr_rd),
        .csr_wr    (csr_wr),
        .is_mret   (is_mret),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .pc        (pc),
        .timer_irq (timer_irq),
        .ext_irq   (ext_irq),
        .csr_rdata (csr_rdata),
        .epc_taken (epc_taken),
        .epc       (epc)
    );

    typedef struct {
        logic        rst;
        logic        rd;
        logic        wr;
        logic        mret;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] pcv;
        logic        t;
        logic        e;
        logic [31:0] exp_rdata;
        logic        exp_tk;
        logic [31:0] exp_epc;
    } vec_t;

    typedef struct {
        int          row;
        logic [31:0] rdata;
        logic        tk;
        logic [31:0] epc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    exp_t e_push, e_pop;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic found;

    function automatic vec_t v(logic rst, logic rd, logic wr, logic mret, logic [11:0] a,
                               logic [31:0] wd, logic [31:0] pcv, logic t, logic e,
                               logic [31:0] er, logic tk, logic [31:0] ee);
        vec_t r;
        r.rst = rst; r.rd = rd; r.wr = wr; r.mret = mret; r.addr = a; r.wdata = wd;
        r.pcv = pcv; r.t = t; r.e = e; r.exp_rdata = er; r.exp_tk = tk; r.exp_epc = ee;
        return r;
    endfunction

    function automatic vec_t R(logic [11:0] a, logic [31:0] er);
        return v(1'b1, 1'b1, 1'b0, 1'b0, a, 32'd0, 32'd0, 1'b0, 1'b0, er, 1'b0, 32'd0);
    endfunction

    function automatic vec_t W(logic [11:0] a, logic [31:0] wd);
        return v(1'b1, 1'b0, 1'b1, 1'b0, a, wd, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp_v);
        end
    endtask

    task automatic apply(input vec_t x, input int row);
        rst_n = x.rst; csr_rd = x.rd; csr_wr = x.wr; is_mret = x.mret;
        csr_addr = x.addr; csr_wdata = x.wdata; pc = x.pcv;
        timer_irq = x.t; ext_irq = x.e;
        e_push.row = row; e_push.rdata = x.exp_rdata; e_push.tk = x.exp_tk; e_push.epc = x.exp_epc;
        sb_q.push_back(e_push);
        @(negedge clk);
        e_pop = sb_q.pop_front();
        check($sformatf("row%0d rdata", e_pop.row), csr_rdata, e_pop.rdata);
        check($sformatf("row%0d epc_taken", e_pop.row), {31'd0, epc_taken}, {31'd0, e_pop.tk});
        if (e_pop.tk) check($sformatf("row%0d epc", e_pop.row), epc, e_pop.epc);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; csr_rd = 1'b0; csr_wr = 1'b0; is_mret = 1'b0;
        csr_addr = 12'd0; csr_wdata = 32'd0; pc = 32'd0; timer_irq = 1'b0; ext_irq = 1'b0;

        // reset with hostile inputs: outputs must stay quiet
        vecs.push_back(v(0, 1, 0, 1, 12'h305, 0, 0, 1, 1, 32'h0, 0, 0));
        vecs.push_back(v(0, 1, 1, 1, 12'h305, 32'h55, 0, 1, 1, 32'h0, 0, 0));
        vecs.push_back(R(12'h305, MTVEC_RST_TB));
        vecs.push_back(R(12'h300, 32'h0));
        vecs.push_back(R(12'h341, 32'h0));
        vecs.push_back(v(1, 1, 1, 0, 12'h305, 32'h0000_0103, 0, 0, 0, MTVEC_RST_TB, 0, 0));
        vecs.push_back(R(12'h305, 32'h0000_0100));
        vecs.push_back(W(12'h344, 32'hFFFF_FFFF));
        vecs.push_back(R(12'h344, 32'h0));
        vecs.push_back(v(1, 1, 1, 0, 12'h7C0, 32'h1234, 0, 0, 0, 32'h0, 0, 0));
        vecs.push_back(W(12'h341, 32'h0000_0047));
        vecs.push_back(R(12'h341, 32'h0000_0044));
        vecs.push_back(W(12'h342, 32'h1234_5678));
        vecs.push_back(R(12'h342, 32'h1234_5678));
        vecs.push_back(W(12'h300, 32'hFFFF_FFFF));
        vecs.push_back(R(12'h300, 32'h0000_0088));
        vecs.push_back(W(12'h300, 32'h0000_0008));
        vecs.push_back(W(12'h304, 32'hFFFF_FFFF));
        vecs.push_back(R(12'h304, 32'h0000_0880));
        vecs.push_back(W(12'h304, 32'h0000_0080));
        vecs.push_back(R(12'h300, 32'h0000_0008));
        // timer interrupt entry
        vecs.push_back(v(1, 1, 0, 0, 12'h344, 0, 32'h40, 1, 0, 32'h0, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 12'h344, 0, 32'h40, 0, 0, 32'h80, 1, 32'h100));
        vecs.push_back(R(12'h341, 32'h0000_0040));
        vecs.push_back(R(12'h342, 32'h8000_0007));
        vecs.push_back(R(12'h300, 32'h0000_0080));
        // pending timer while MIE=0 must not trap
        vecs.push_back(v(1, 1, 0, 0, 12'h300, 0, 32'h44, 1, 0, 32'h80, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 12'h344, 0, 32'h44, 1, 0, 32'h80, 0, 0));
        vecs.push_back(v(1, 1, 0, 1, 12'h300, 0, 32'h44, 0, 0, 32'h80, 1, 32'h40));
        vecs.push_back(R(12'h300, 32'h0000_0088));
        // mret and interrupt in the same cycle: mret first, trap next cycle
        vecs.push_back(v(1, 1, 0, 0, 12'h344, 0, 32'h7C, 1, 0, 32'h0, 0, 0));
        vecs.push_back(v(1, 1, 0, 1, 12'h300, 0, 32'h80, 1, 0, 32'h88, 1, 32'h40));
        vecs.push_back(v(1, 1, 0, 0, 12'h341, 0, 32'h84, 1, 0, 32'h40, 1, 32'h100));
        vecs.push_back(R(12'h341, 32'h0000_0084));
        vecs.push_back(R(12'h300, 32'h0000_0080));
        // both interrupts: external wins, concurrent mepc write is dropped
        vecs.push_back(W(12'h304, 32'h0000_0880));
        vecs.push_back(W(12'h300, 32'h0000_0008));
        vecs.push_back(v(1, 1, 0, 0, 12'h300, 0, 32'hBC, 1, 1, 32'h08, 0, 0));
        vecs.push_back(v(1, 1, 1, 0, 12'h341, 32'hDEAD_BEE0, 32'hC0, 1, 1, 32'h84, 1, 32'h100));
        vecs.push_back(R(12'h342, 32'h8000_000B));
        vecs.push_back(R(12'h341, 32'h0000_00C0));
        vecs.push_back(R(12'h300, 32'h0000_0080));
        // reset arriving while a trap is pending
        vecs.push_back(W(12'h300, 32'h0000_0008));
        vecs.push_back(v(1, 1, 0, 0, 12'h300, 0, 32'hF0, 0, 1, 32'h08, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 12'h344, 0, 32'h100, 0, 1, 32'h0, 0, 0));
        vecs.push_back(R(12'h341, 32'h0));
        vecs.push_back(R(12'h305, MTVEC_RST_TB));
        vecs.push_back(R(12'h300, 32'h0));
        vecs.push_back(R(12'h304, 32'h0));
        // mcycle carry across halves
        vecs.push_back(W(12'hB00, 32'hFFFF_FFFF));
        vecs.push_back(W(12'hB80, 32'h0));
        vecs.push_back(R(12'hB00, MC ? 32'hFFFF_FFFF : 32'h0));
        vecs.push_back(R(12'hB00, 32'h0));
        vecs.push_back(R(12'hB80, MC ? 32'h1 : 32'h0));

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // external interrupt alone, bounded wait for the redirect
        apply(W(12'h304, 32'h0000_0800), 1000);
        apply(W(12'h300, 32'h0000_0008), 1001);
        rst_n = 1'b1; csr_rd = 1'b0; csr_wr = 1'b0; is_mret = 1'b0;
        csr_addr = 12'd0; csr_wdata = 32'd0; pc = 32'h300; timer_irq = 1'b0; ext_irq = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 5 && !found; k++) begin
            @(negedge clk);
            if (epc_taken) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("ext_irq redirect seen", {31'd0, found}, 32'd1);
        if (found) check("ext_irq epc", epc, MTVEC_RST_TB);
        @(posedge clk);
        #1;
        ext_irq = 1'b0; csr_rd = 1'b1; csr_addr = 12'h342;
        @(negedge clk);
        check("ext_irq mcause", csr_rdata, 32'h8000_000B);
        csr_addr = 12'h341;
        #1;
        check("ext_irq mepc", csr_rdata, 32'h0000_0300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
